// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared types, widths and step-count helper for the shift sequencer
package shift_pkg;

  localparam int DATA_W  = 32;
  localparam int COUNT_W = 6;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_type_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  // Number of one-bit steps needed; beyond 33 (LSL/LSR) or 32 (ASR) the result no longer changes.
  function automatic logic [COUNT_W-1:0] calc_steps(input shift_type_e kind, input logic [7:0] amount);
    logic [COUNT_W-1:0] steps;
    steps = '0;
    case (kind)
      SH_LSL, SH_LSR: steps = (amount > 8'd33) ? 6'd33 : amount[5:0];
      SH_ASR:         steps = (amount > 8'd32) ? 6'd32 : amount[5:0];
      default: begin
        // A nonzero multiple of 32 rotates a full turn so the carry still reflects bit 31.
        if (amount[4:0] == 5'd0)
          steps = (amount != 8'd0) ? 6'd32 : 6'd0;
        else
          steps = {1'b0, amount[4:0]};
      end
    endcase
    return steps;
  endfunction

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - combinational one-bit shift of the working data
import shift_pkg::*;

module shift_step (
  input  logic [DATA_W-1:0] data,
  input  shift_type_e       kind,
  output logic [DATA_W-1:0] next_data,
  output logic              shift_out
);

  // One bit position per call; the departing bit becomes the new carry.
  always_comb begin
    next_data = data;
    shift_out = 1'b0;
    case (kind)
      SH_LSL: begin
        next_data = {data[DATA_W-2:0], 1'b0};
        shift_out = data[DATA_W-1];
      end
      SH_LSR: begin
        next_data = {1'b0, data[DATA_W-1:1]};
        shift_out = data[0];
      end
      SH_ASR: begin
        next_data = {data[DATA_W-1], data[DATA_W-1:1]};
        shift_out = data[0];
      end
      default: begin
        next_data = {data[0], data[DATA_W-1:1]};
        shift_out = data[0];
      end
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - iterative barrel-shift replacement, one bit per clock
import shift_pkg::*;

module shift_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             reqValid,
  output logic             reqReady,
  input  logic [1:0]       shiftType,
  input  logic [7:0]       shiftAmount,
  input  logic [WIDTH-1:0] rmData,
  input  logic             carryIn,
  input  logic             abort,
  output logic             resValid,
  input  logic             resReady,
  output logic [WIDTH-1:0] shiftedData,
  output logic             carryOut,
  output logic             busy
);

  state_e             state;
  state_e             state_next;
  shift_type_e        kind;
  logic [COUNT_W-1:0] count;
  logic [WIDTH-1:0]   work_data;
  logic               carry;
  logic [COUNT_W-1:0] req_steps;
  logic [WIDTH-1:0]   step_data;
  logic               step_out;

  assign req_steps = calc_steps(shift_type_e'(shiftType), shiftAmount);

  shift_step u_step (
    .data      (work_data),
    .kind      (kind),
    .next_data (step_data),
    .shift_out (step_out)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= ST_IDLE;
    else
      state <= state_next;
  end

  // Next-state logic; abort overrides every other transition.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (reqValid) state_next = (req_steps == '0) ? ST_DONE : ST_SHIFT;
      ST_SHIFT: if (count == 6'd1) state_next = ST_DONE;
      ST_DONE:  if (resReady) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
    if (abort)
      state_next = ST_IDLE;
  end

  // Handshake outputs decoded from the state.
  always_comb begin
    reqReady = 1'b0;
    resValid = 1'b0;
    busy     = 1'b0;
    case (state)
      ST_IDLE:  reqReady = 1'b1;
      ST_SHIFT: busy     = 1'b1;
      ST_DONE: begin
        resValid = 1'b1;
        busy     = 1'b1;
      end
      default:  reqReady = 1'b0;
    endcase
  end

  // Operand capture on accept, then one shift step per cycle; data/carry hold in DONE and IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kind      <= SH_LSL;
      count     <= '0;
      work_data <= '0;
      carry     <= 1'b0;
    end else if (abort) begin
      count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (reqValid) begin
            kind      <= shift_type_e'(shiftType);
            work_data <= rmData;
            carry     <= carryIn;
            count     <= req_steps;
          end
        end
        ST_SHIFT: begin
          work_data <= step_data;
          carry     <= step_out;
          count     <= count - 6'd1;
        end
        default: count <= count;
      endcase
    end
  end

  assign shiftedData = work_data;
  assign carryOut    = carry;

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - self-checking bench for shift_sequencer
module tb_shift_sequencer;

  logic        clk;
  logic        reset;
  logic        reqValid;
  logic        reqReady;
  logic [1:0]  shiftType;
  logic [7:0]  shiftAmount;
  logic [31:0] rmData;
  logic        carryIn;
  logic        abort;
  logic        resValid;
  logic        resReady;
  logic [31:0] shiftedData;
  logic        carryOut;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  shift_sequencer #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .reqValid    (reqValid),
    .reqReady    (reqReady),
    .shiftType   (shiftType),
    .shiftAmount (shiftAmount),
    .rmData      (rmData),
    .carryIn     (carryIn),
    .abort       (abort),
    .resValid    (resValid),
    .resReady    (resReady),
    .shiftedData (shiftedData),
    .carryOut    (carryOut),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]  typ;
    logic [7:0]  amt;
    logic [31:0] rm;
    logic        cin;
    logic [31:0] exp_data;
    logic        exp_c;
    int          exp_lat;
    int          hold;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Architectural shifter semantics computed directly from shift type and register amount.
  function automatic void ref_model(input int t, input int amt, input logic [31:0] rm, input logic cin,
                                    output logic [31:0] d, output logic c, output int lat);
    int r;
    d = rm; c = cin; lat = 0;
    if (t == 0) begin
      lat = (amt > 33) ? 33 : amt;
      if (amt == 0) begin d = rm; c = cin; end
      else if (amt < 32) begin d = rm << amt; c = rm[32-amt]; end
      else if (amt == 32) begin d = 0; c = rm[0]; end
      else begin d = 0; c = 1'b0; end
    end else if (t == 1) begin
      lat = (amt > 33) ? 33 : amt;
      if (amt == 0) begin d = rm; c = cin; end
      else if (amt < 32) begin d = rm >> amt; c = rm[amt-1]; end
      else if (amt == 32) begin d = 0; c = rm[31]; end
      else begin d = 0; c = 1'b0; end
    end else if (t == 2) begin
      lat = (amt > 32) ? 32 : amt;
      if (amt == 0) begin d = rm; c = cin; end
      else if (amt < 32) begin d = 32'($signed(rm) >>> amt); c = rm[amt-1]; end
      else begin d = {32{rm[31]}}; c = rm[31]; end
    end else begin
      r = amt % 32;
      if (amt == 0) begin d = rm; c = cin; lat = 0; end
      else if (r == 0) begin d = rm; c = rm[31]; lat = 32; end
      else begin d = (rm >> r) | (rm << (32 - r)); c = rm[r-1]; lat = r; end
    end
  endfunction

  task automatic run_op(input vec_t v, input string tag);
    int lat;
    @(negedge clk);
    check({tag, " reqReady before accept"}, 32'(reqReady), 32'd1);
    reqValid = 1'b1; shiftType = v.typ; shiftAmount = v.amt; rmData = v.rm; carryIn = v.cin;
    resReady = 1'b0;
    @(negedge clk);
    reqValid = 1'b0;
    shiftType = 2'($urandom); shiftAmount = 8'($urandom); rmData = $urandom; carryIn = 1'($urandom);
    lat = 0;
    while (!resValid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(v.exp_lat));
    check({tag, " data"}, shiftedData, v.exp_data);
    check({tag, " carry"}, 32'(carryOut), 32'(v.exp_c));
    for (int i = 0; i < v.hold; i++) begin
      @(negedge clk);
      check({tag, " hold valid"}, 32'(resValid), 32'd1);
      check({tag, " hold data"}, shiftedData, v.exp_data);
      check({tag, " hold carry"}, 32'(carryOut), 32'(v.exp_c));
    end
    resReady = 1'b1;
    reqValid = 1'b1;
    @(negedge clk);
    check({tag, " idle after release"}, 32'(reqReady), 32'd1);
    check({tag, " no accept on release"}, 32'(busy), 32'd0);
    resReady = 1'b0;
    reqValid = 1'b0;
  endtask

  vec_t tbl[9];
  vec_t rv;
  int   seen;

  initial begin
    reset = 1'b1; reqValid = 1'b0; shiftType = 2'd0; shiftAmount = 8'd0;
    rmData = 32'd0; carryIn = 1'b0; abort = 1'b0; resReady = 1'b0;

    tbl[0] = '{2'd0, 8'd1,   32'h80000001, 1'b0, 32'h00000002, 1'b1, 1,  0};
    tbl[1] = '{2'd1, 8'd32,  32'h80000000, 1'b0, 32'h00000000, 1'b1, 32, 0};
    tbl[2] = '{2'd1, 8'd40,  32'h80000000, 1'b1, 32'h00000000, 1'b0, 33, 0};
    tbl[3] = '{2'd2, 8'd200, 32'h80000000, 1'b0, 32'hFFFFFFFF, 1'b1, 32, 1};
    tbl[4] = '{2'd3, 8'd4,   32'h0000000F, 1'b0, 32'hF0000000, 1'b1, 4,  0};
    tbl[5] = '{2'd3, 8'd32,  32'h0000000F, 1'b1, 32'h0000000F, 1'b0, 32, 0};
    tbl[6] = '{2'd0, 8'd0,   32'h12345678, 1'b1, 32'h12345678, 1'b1, 0,  5};
    tbl[7] = '{2'd3, 8'd64,  32'h80000000, 1'b0, 32'h80000000, 1'b1, 32, 0};
    tbl[8] = '{2'd0, 8'd32,  32'h00000001, 1'b0, 32'h00000000, 1'b1, 32, 2};

    #12;
    check("reset reqReady", 32'(reqReady), 32'd1);
    check("reset resValid", 32'(resValid), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset data", shiftedData, 32'd0);
    check("reset carry", 32'(carryOut), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 9; i++)
      run_op(tbl[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 40; i++) begin
      int lat;
      rv.typ = 2'($urandom_range(0, 3));
      rv.amt = ($urandom_range(0, 1) == 0) ? 8'($urandom) : 8'($urandom_range(0, 40));
      rv.rm  = $urandom;
      rv.cin = 1'($urandom);
      rv.hold = $urandom_range(0, 2);
      ref_model(int'(rv.typ), int'(rv.amt), rv.rm, rv.cin, rv.exp_data, rv.exp_c, lat);
      rv.exp_lat = lat;
      run_op(rv, $sformatf("rnd%0d t%0d a%0d", i, rv.typ, rv.amt));
    end

    // Abort on the third SHIFT edge of LSL by 20.
    @(negedge clk);
    reqValid = 1'b1; shiftType = 2'd0; shiftAmount = 8'd20; rmData = $urandom; carryIn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reqValid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort reqReady", 32'(reqReady), 32'd1);
    check("abort busy", 32'(busy), 32'd0);
    check("abort resValid", 32'(resValid), 32'd0);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (resValid) seen++;
    end
    check("abort no result", 32'(seen), 32'd0);

    // Abort wins over a request in IDLE.
    reqValid = 1'b1; abort = 1'b1; shiftAmount = 8'd5;
    @(negedge clk);
    check("abort beats req", 32'(reqReady), 32'd1);
    check("abort beats req busy", 32'(busy), 32'd0);
    reqValid = 1'b0; abort = 1'b0;

    // Asynchronous reset in the middle of a shift.
    @(negedge clk);
    reqValid = 1'b1; shiftType = 2'd1; shiftAmount = 8'd20; rmData = 32'hDEADBEEF; carryIn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reqValid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("rst reqReady", 32'(reqReady), 32'd1);
    check("rst busy", 32'(busy), 32'd0);
    check("rst resValid", 32'(resValid), 32'd0);
    check("rst data", shiftedData, 32'd0);
    check("rst carry", 32'(carryOut), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (resValid) seen++;
    end
    check("rst no result", 32'(seen), 32'd0);

    run_op(tbl[0], "after reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 SHALL have parameter: WIDTH, 32, datapath width (only 32 supported).
REQ-002 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port: reqValid  in  1  request present.
REQ-005 SHALL have port: reqReady  out  1  block can accept a request.
REQ-006 SHALL have port: shiftType  in  2  00 LSL, 01 LSR, 10 ASR, 11 ROR.
REQ-007 SHALL have port: shiftAmount  in  8  register-specified amount (Rs[7:0]).
REQ-008 SHALL have port: rmData  in  32  operand to shift.
REQ-009 SHALL have port: carryIn  in  1  current C flag.
REQ-010 SHALL have port: abort  in  1  synchronous cancel (pipeline flush).
REQ-011 SHALL have port: resValid  out  1  result valid.
REQ-012 SHALL have port: resReady  in  1  consumer takes result.
REQ-013 SHALL have port: shiftedData  out  32  shift result.
REQ-014 SHALL have port: carryOut  out  1  shifter carry-out.
REQ-015 SHALL have port: busy  out  1  high in SHIFT or DONE.

Function
REQ-016 SHALL implement states IDLE, SHIFT, DONE; reqReady high only in IDLE, resValid high only in DONE, busy high in SHIFT or DONE.
REQ-017 SHALL accept a request on an edge with state IDLE, reqValid=1, abort=0, latching shiftType, rmData, carryIn and the step count N.
REQ-018 SHALL compute N: LSL/LSR min(shiftAmount,33); ASR min(shiftAmount,32); ROR shiftAmount[4:0], except 32 when shiftAmount!=0 and shiftAmount[4:0]=0.
REQ-019 SHALL on accept with N=0 go directly to DONE with shiftedData=rmData, carryOut=carryIn.
REQ-020 SHALL on accept with N>=1 go to SHIFT with count=N and carry register=carryIn.
REQ-021 SHALL in SHIFT, each edge, shift working data by exactly one bit of the latched type, load carry with the bit shifted out, decrement count; at count=1 transition to DONE.
REQ-022 SHALL zero-fill for LSL/LSR, replicate bit 31 for ASR, and move bit 0 to bit 31 for ROR.
REQ-023 SHALL make the result visible (resValid=1) after edge k+N for accept edge k and N>=1, or after edge k for N=0; maximum 33 SHIFT cycles.
REQ-024 SHALL hold shiftedData and carryOut stable while in DONE and resReady=0.
REQ-025 SHALL return to IDLE on the edge where DONE and resReady=1; no new request accepted on that edge.
REQ-026 SHALL on abort=1 at any edge return to IDLE, discard any in-flight or pending result; abort beats reqValid in IDLE.
REQ-027 SHALL ignore changes on request inputs after accept.
REQ-028 SHALL keep shiftedData and carryOut at last value in IDLE (not required valid).

Reset
REQ-029 SHALL on reset=1 immediately force state IDLE, count 0, shiftedData 0, carryOut 0, resValid 0, busy 0, reqReady 1, regardless of clk.
REQ-030 SHALL on reset during SHIFT or DONE discard the operation without producing resValid.

Structure
REQ-031 SHALL place shift-type encodings, state enumeration and count width (6 bits) in shared package shift_pkg.
REQ-032 SHALL use one sub-module shift_step: combinational one-bit shift of data/type returning next data and bit shifted out.

Verification
REQ-033 SHALL cover: LSL, rmData=0x80000001, amount=1, carryIn=0 -> resValid after 1 edge, shiftedData=0x00000002, carryOut=1.
REQ-034 SHALL cover: LSR, rmData=0x80000000, amount=32 -> 32 SHIFT cycles, shiftedData=0, carryOut=1; amount=40 -> 33 cycles, shiftedData=0, carryOut=0.
REQ-035 SHALL cover: ASR, rmData=0x80000000, amount=200 -> 32 cycles, shiftedData=0xFFFFFFFF, carryOut=1.
REQ-036 SHALL cover: ROR, rmData=0x0000000F, amount=4 -> shiftedData=0xF0000000, carryOut=1; amount=32 -> shiftedData=0x0000000F, carryOut=0.
REQ-037 SHALL cover: amount=0, carryIn=1 -> resValid after accept edge, shiftedData=rmData, carryOut=1; resReady held 0 for 5 cycles -> outputs stable.
REQ-038 SHALL cover: abort at SHIFT cycle 3 of LSL by 20, and async reset mid-SHIFT -> IDLE next state, resValid never asserted, reqReady=1.
